// File: rtl/ldpc_out_pack_if.sv
// ldpc_out_pack_if: bit-stream input and byte-stream output bundle for ldpc_out_pack
//   rate, en_in, din, sync_in : decoded-bit side (driven by the decoder)
//   out_rdy                   : downstream ready
//   out_valid, out_byte,
//   out_sof, out_eof          : packed-byte side (driven by the packer)
interface ldpc_out_pack_if;
    logic       rate;
    logic       en_in;
    logic       din;
    logic       sync_in;
    logic       out_rdy;
    logic       out_valid;
    logic [7:0] out_byte;
    logic       out_sof;
    logic       out_eof;
    modport master (
        output rate, en_in, din, sync_in, out_rdy,
        input  out_valid, out_byte, out_sof, out_eof
    );
    modport slave (
        input  rate, en_in, din, sync_in, out_rdy,
        output out_valid, out_byte, out_sof, out_eof
    );
endinterface

// File: rtl/ldpc_out_pack.sv
// ldpc_out_pack: packs decoded LDPC info bits MSB-first into bytes and queues them with frame markers
//   clk     : clock, rising edge
//   reset   : asynchronous active-high reset
//   bus     : ldpc_out_pack_if.slave (bit input, byte output with valid/ready)
//   frm_err : one-cycle pulse when a frame is cut short by a new sync
//   ovf     : sticky FIFO overflow flag
module ldpc_out_pack #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    ldpc_out_pack_if.slave   bus,
    output logic             frm_err,
    output logic             ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic {IDLE, PACK} state_t;
    state_t      state, state_n;
    logic [12:0] cnt, cnt_n, cnt_inc, k;
    logic [7:0]  sr;
    logic        rate_q, start, take, push, err_n, pop, full, wr;
    logic [9:0]  push_ent;
    logic [9:0]  mem [FIFO_DEPTH];
    logic [AW:0] wp, rp, occ;
    assign k       = rate_q ? 13'd6912 : 13'd4608;
    assign cnt_inc = cnt + 13'd1;
    assign start   = bus.en_in & bus.sync_in;
    assign take    = bus.en_in & ~bus.sync_in & (state == PACK);
    // The 8th bit of a byte is taken straight from din so the byte is pushed on the same edge.
    assign push_ent = {cnt_inc == 13'd8, cnt_inc == k, sr[6:0], bus.din};
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        push    = 1'b0;
        err_n   = 1'b0;
        if (start) begin
            state_n = PACK;
            cnt_n   = 13'd1;
            err_n   = (state == PACK);
        end else if (take) begin
            cnt_n = cnt_inc;
            push  = (cnt_inc[2:0] == 3'd0);
            if (cnt_inc == k) begin
                state_n = IDLE;
                cnt_n   = 13'd0;
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 13'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    // Older bits left in sr on a restart are shifted out before they can reach a byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr      <= 8'd0;
            rate_q  <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            frm_err <= err_n;
            if (start) rate_q <= bus.rate;
            if (start | take) sr <= {sr[6:0], bus.din};
        end
    end
    // Pointers carry one extra bit so full and empty are distinguishable.
    assign occ  = wp - rp;
    assign full = (occ == (AW+1)'(FIFO_DEPTH));
    assign pop  = bus.out_valid & bus.out_rdy;
    assign wr   = push & (~full | pop);
    always_ff @(posedge clk) begin
        if (wr) mem[wp[AW-1:0]] <= push_ent;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            ovf <= 1'b0;
        end else begin
            if (wr) wp <= wp + (AW+1)'(1);
            if (pop) rp <= rp + (AW+1)'(1);
            if (push & full & ~pop) ovf <= 1'b1;
        end
    end
    // Head is masked when empty so stale memory never shows on the outputs.
    assign bus.out_valid = (occ != '0);
    assign {bus.out_sof, bus.out_eof, bus.out_byte} = bus.out_valid ? mem[rp[AW-1:0]] : 10'd0;
endmodule

// File: tb/tb_ldpc_out_pack.sv
// tb_ldpc_out_pack: randomized self-checking bench for ldpc_out_pack against a frame/queue reference model
module tb_ldpc_out_pack;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frm_err, ovf;
    ldpc_out_pack_if bus();
    ldpc_out_pack #(.FIFO_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus), .frm_err(frm_err), .ovf(ovf));
    always #5 clk = ~clk;
    int n_chk = 0;
    int n_fail = 0;
    logic [9:0] mq[$];
    bit in_frame;
    int nbits, k;
    logic [7:0] acc;
    bit m_ovf, m_err;
    int obs_n, obs_sof, obs_eof, obs_eof_at;
    logic [12:0] got, want;
    task automatic model_edge(input bit en, input bit d, input bit s, input bit r, input bit rt);
        bit pushv = 0;
        logic [9:0] pe = '0;
        int pre = mq.size();
        bit pop = (pre > 0) && r;
        m_err = 0;
        if (en) begin
            if (s) begin
                m_err = in_frame;
                in_frame = 1;
                k = rt ? 6912 : 4608;
                nbits = 0;
            end
            if (in_frame) begin
                acc = {acc[6:0], d};
                nbits++;
                if (nbits % 8 == 0) begin
                    pushv = 1;
                    pe = {nbits == 8, nbits == k, acc};
                end
                if (nbits == k) in_frame = 0;
            end
        end
        if (pop) void'(mq.pop_front());
        if (pushv) begin
            if (pre < DEPTH || pop) mq.push_back(pe);
            else m_ovf = 1;
        end
    endtask
    task automatic cyc(input bit en, input bit d, input bit s, input bit r, input bit rt);
        @(negedge clk);
        bus.en_in = en;
        bus.din = d;
        bus.sync_in = s;
        bus.out_rdy = r;
        bus.rate = rt;
        #1;
        if (bus.out_valid && r) begin
            obs_n++;
            obs_sof += int'(bus.out_sof);
            if (bus.out_eof) begin
                obs_eof++;
                obs_eof_at = obs_n;
            end
        end
        @(posedge clk);
        model_edge(en, d, s, r, rt);
        #1;
        got = {bus.out_valid, bus.out_sof, bus.out_eof, bus.out_byte, frm_err, ovf};
        want = {mq.size() != 0, (mq.size() != 0) ? mq[0] : 10'h0, m_err, m_ovf};
    endtask
    task automatic clear_model();
        mq.delete();
        in_frame = 0;
        nbits = 0;
        acc = '0;
        m_ovf = 0;
        m_err = 0;
        obs_n = 0;
        obs_sof = 0;
        obs_eof = 0;
        obs_eof_at = 0;
    endtask
    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        bus.en_in = 0;
        bus.din = 0;
        bus.sync_in = 0;
        bus.out_rdy = 0;
        bus.rate = 0;
        clear_model();
        @(posedge clk);
        @(negedge clk);
        reset = 0;
    endtask
    task automatic test_reset();
        logic [12:0] z;
        bus.en_in = 0;
        bus.din = 0;
        bus.sync_in = 0;
        bus.out_rdy = 0;
        bus.rate = 0;
        clear_model();
        @(posedge clk);
        #1;
        n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        n_chk++; if (bus.out_byte !== 8'h00) begin n_fail++; $display("FAIL reset_byte got %h want 00", bus.out_byte); end
        n_chk++; if (bus.out_sof !== 1'b0) begin n_fail++; $display("FAIL reset_sof got %b want 0", bus.out_sof); end
        n_chk++; if (bus.out_eof !== 1'b0) begin n_fail++; $display("FAIL reset_eof got %b want 0", bus.out_eof); end
        n_chk++; if (frm_err !== 1'b0) begin n_fail++; $display("FAIL reset_frm_err got %b want 0", frm_err); end
        n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
        @(negedge clk);
        reset = 0;
        z = 0;
        cyc(1, 1, 0, 1, 0);
        n_chk++; if (got !== z) begin n_fail++; $display("FAIL idle_no_sync got %h want %h", got, z); end
    endtask
    task automatic test_frame_rate0();
        logic [7:0] pat = 8'hA5;
        do_reset();
        for (int i = 0; i < 4608 + 3; i++) begin
            if (i < 4608) cyc(1, pat[7 - (i % 8)], i == 0, 1, 0);
            else cyc(0, 0, 0, 1, 0);
            n_chk++; if (got !== want) begin n_fail++; $display("FAIL frame_r0 cyc %0d got %h want %h", i, got, want); end
        end
        n_chk++; if (obs_n !== 576) begin n_fail++; $display("FAIL r0_bytes got %0d want 576", obs_n); end
        n_chk++; if (obs_sof !== 1) begin n_fail++; $display("FAIL r0_sof_count got %0d want 1", obs_sof); end
        n_chk++; if (obs_eof !== 1 || obs_eof_at !== 576) begin n_fail++; $display("FAIL r0_eof got count %0d at %0d want 1 at 576", obs_eof, obs_eof_at); end
    endtask
    task automatic test_frame_rate1();
        int v = 0;
        int c = 0;
        do_reset();
        while (v < 6912 && c < 20000) begin
            bit en = (v == 0) || ($urandom_range(3) != 0);
            bit s = (v == 0) ? 1'b1 : (en ? 1'b0 : 1'($urandom_range(1)));
            bit rt = (v == 0) ? 1'b1 : 1'($urandom_range(1));
            cyc(en, 1'($urandom_range(1)), s, $urandom_range(3) != 0, rt);
            if (en) v++;
            c++;
            n_chk++; if (got !== want) begin n_fail++; $display("FAIL frame_r1 cyc %0d got %h want %h", c, got, want); end
        end
        n_chk++; if (v != 6912) begin n_fail++; $display("FAIL r1_budget got %0d bits want 6912", v); end
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 1, 0);
            n_chk++; if (got !== want) begin n_fail++; $display("FAIL r1_drain cyc %0d got %h want %h", i, got, want); end
        end
        n_chk++; if (obs_n !== 864) begin n_fail++; $display("FAIL r1_bytes got %0d want 864", obs_n); end
        n_chk++; if (obs_sof !== 1) begin n_fail++; $display("FAIL r1_sof_count got %0d want 1", obs_sof); end
        n_chk++; if (obs_eof !== 1 || obs_eof_at !== 864) begin n_fail++; $display("FAIL r1_eof got count %0d at %0d want 1 at 864", obs_eof, obs_eof_at); end
    endtask
    task automatic test_abort();
        do_reset();
        for (int i = 0; i < 35; i++) begin
            cyc(1, 1'($urandom_range(1)), i == 0 || i == 19, 1, 0);
            n_chk++; if (got !== want) begin n_fail++; $display("FAIL abort cyc %0d got %h want %h", i, got, want); end
            if (i == 19) begin
                n_chk++; if (frm_err !== 1'b1) begin n_fail++; $display("FAIL abort_err_pulse got %b want 1", frm_err); end
            end
            if (i == 20) begin
                n_chk++; if (frm_err !== 1'b0) begin n_fail++; $display("FAIL abort_err_width got %b want 0", frm_err); end
            end
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
        n_chk++; if (obs_n !== 4) begin n_fail++; $display("FAIL abort_bytes got %0d want 4", obs_n); end
        n_chk++; if (obs_eof !== 0) begin n_fail++; $display("FAIL abort_eof got %0d want 0", obs_eof); end
        n_chk++; if (obs_sof !== 2) begin n_fail++; $display("FAIL abort_sof got %0d want 2", obs_sof); end
    endtask
    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 48; i++) begin
            cyc(1, 1'($urandom_range(1)), i == 0, 0, 0);
            n_chk++; if (got !== want) begin n_fail++; $display("FAIL ovf_fill cyc %0d got %h want %h", i, got, want); end
            if (i == 38) begin
                n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b want 0", ovf); end
            end
            if (i == 39) begin
                n_chk++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", ovf); end
            end
        end
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 1, 0);
            n_chk++; if (got !== want) begin n_fail++; $display("FAIL ovf_drain cyc %0d got %h want %h", i, got, want); end
        end
        n_chk++; if (obs_n !== 4) begin n_fail++; $display("FAIL ovf_bytes got %0d want 4", obs_n); end
    endtask
    task automatic test_full_simul();
        do_reset();
        for (int i = 0; i < 56; i++) begin
            cyc(1, 1'($urandom_range(1)), i == 0, i >= 32 && (i % 8) == 7, 0);
            n_chk++; if (got !== want) begin n_fail++; $display("FAIL full_simul cyc %0d got %h want %h", i, got, want); end
            if (i >= 32 && (i % 8) == 7) begin
                n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL full_simul_ovf bit %0d got %b want 0", i, ovf); end
            end
        end
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 1, 0);
            n_chk++; if (got !== want) begin n_fail++; $display("FAIL full_drain cyc %0d got %h want %h", i, got, want); end
        end
        n_chk++; if (obs_n !== 7) begin n_fail++; $display("FAIL full_simul_bytes got %0d want 7", obs_n); end
    endtask
    task automatic test_reset_midframe();
        do_reset();
        for (int i = 0; i < 2999; i++) begin
            cyc(1, 1'($urandom_range(1)), i == 0, $urandom_range(1) != 0, 0);
            n_chk++; if (got !== want) begin n_fail++; $display("FAIL midframe cyc %0d got %h want %h", i, got, want); end
        end
        @(negedge clk);
        bus.en_in = 1;
        bus.din = 1;
        bus.sync_in = 0;
        #2 reset = 1;
        #1;
        got = {bus.out_valid, bus.out_sof, bus.out_eof, bus.out_byte, frm_err, ovf};
        n_chk++; if (got !== 13'h0) begin n_fail++; $display("FAIL midframe_reset got %h want 0000", got); end
        clear_model();
        @(posedge clk);
        @(negedge clk);
        bus.en_in = 0;
        reset = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1, 1'($urandom_range(1)), 0, 1, 0);
            n_chk++; if (got !== want) begin n_fail++; $display("FAIL post_reset_idle cyc %0d got %h want %h", i, got, want); end
        end
        n_chk++; if (obs_n !== 0) begin n_fail++; $display("FAIL post_reset_bytes got %0d want 0", obs_n); end
        for (int i = 0; i < 67; i++) begin
            if (i < 64) cyc(1, 1'($urandom_range(1)), i == 0, 1, 0);
            else cyc(0, 0, 0, 1, 0);
            n_chk++; if (got !== want) begin n_fail++; $display("FAIL restart cyc %0d got %h want %h", i, got, want); end
        end
        n_chk++; if (obs_n !== 8 || obs_sof !== 1) begin n_fail++; $display("FAIL restart_bytes got %0d sof %0d want 8 sof 1", obs_n, obs_sof); end
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    initial begin
        test_reset();
        test_frame_rate0();
        test_frame_rate1();
        test_abort();
        test_overflow();
        test_full_simul();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
